// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 16;

  // Pointer width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered read port.
// Only the read register is reset; the storage contents are not.
module fifo_mem #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // rdata holds its value unless a read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with full/empty flags and registered read data.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        wr_en,
  output logic                        full_flag,
  output logic [WIDTH-1:0]            rdata,
  input  logic                        rd_en,
  output logic                        empty_flag,
  output logic [ptr_width(DEPTH)-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                        overflow,
  output logic                        underflow
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PW     = ptr_width(DEPTH);

  logic [PW-1:0] wptr_d, wptr_q, rptr_d, rptr_q, count_d, count_q;
  logic          wr_acc, rd_acc;

  // Wrap bit (MSB) distinguishes full from empty when the addresses match.
  assign empty_flag = (wptr_q == rptr_q);
  assign full_flag  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                      (wptr_q[ADDR_W] != rptr_q[ADDR_W]);

  always_comb begin
    wr_acc  = wr_en && !full_flag;
    rd_acc  = rd_en && !empty_flag;
    wptr_d  = wr_acc ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + PW'(wr_acc) - PW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wptr_q[ADDR_W-1:0]),
    .wdata(wdata),
    .re   (rd_acc),
    .raddr(rptr_q[ADDR_W-1:0]),
    .rdata(rdata)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_d, overflow_q, underflow_d, underflow_q;

  always_comb begin
    overflow_d  = overflow_q  || (wr_en && full_flag);
    underflow_d = underflow_q || (rd_en && empty_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed and random traffic against a queue-based model.
module tb_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = fifo_pkg::ptr_width(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] wdata;
  logic             wr_en, rd_en;
  logic             full_flag, empty_flag;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow, underflow;
`endif

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wdata     (wdata),
    .wr_en     (wr_en),
    .full_flag (full_flag),
    .rdata     (rdata),
    .rd_en     (rd_en),
    .empty_flag(empty_flag),
    .count     (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_ovf, m_udf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_rdata"}, 64'(rdata), 64'(m_rdata));
    chk({tag, "_count"}, 64'(count), 64'(m_q.size()));
    chk({tag, "_empty"}, 64'(empty_flag), 64'(m_q.size() == 0));
    chk({tag, "_full"},  64'(full_flag),  64'(m_q.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, "_ovf"}, 64'(overflow),  64'(m_ovf));
    chk({tag, "_udf"}, 64'(underflow), 64'(m_udf));
`endif
  endtask

  // One clock: drive requests, advance the model using pre-edge occupancy, check after the edge.
  task automatic step(input string tag, input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    wr_en = wr; rd_en = rd; wdata = d; rst = 1'b0;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    @(posedge clk);
    if (rd && !was_empty) m_rdata = m_q.pop_front();
    if (wr && !was_full)  m_q.push_back(d);
    if (wr && was_full)   m_ovf = 1'b1;
    if (rd && was_empty)  m_udf = 1'b1;
    #1;
    chk_all(tag);
  endtask

  // Requests held high during reset to confirm reset wins.
  task automatic do_reset(input string tag);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    m_q.delete(); m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, WIDTH'(i));
    chk("fill_count16", 64'(count), 64'd16);
    chk("fill_full", 64'(full_flag), 64'd1);

    step("ovf_write", 1'b1, 1'b0, 32'd99);
    chk("ovf_count16", 64'(count), 64'd16);

    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b1, '0);
      chk("drain_order", 64'(rdata), 64'(i));
    end
    step("udf_read", 1'b0, 1'b1, '0);
    chk("udf_hold15", 64'(rdata), 64'd15);

    for (int i = 0; i < 10; i++) step("wrap_w10", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 10; i++) step("wrap_r10", 1'b0, 1'b1, '0);
    for (int i = 0; i < 12; i++) step("wrap_w12", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 12; i++) step("wrap_r12", 1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) step("conc_fill5", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) step("conc_rw", 1'b1, 1'b1, $urandom);
    chk("conc_count5", 64'(count), 64'd5);
    for (int i = 0; i < 5; i++) step("conc_drain", 1'b0, 1'b1, '0);
    step("conc_empty", 1'b1, 1'b1, 32'h1234_5678);
    chk("conc_empty_cnt1", 64'(count), 64'd1);
    for (int i = 0; i < DEPTH - 1; i++) step("conc_refill", 1'b1, 1'b0, $urandom);
    step("conc_full", 1'b1, 1'b1, 32'hCAFE_F00D);
    chk("conc_full_cnt15", 64'(count), 64'd15);

    for (int i = 0; i < 400; i++)
      step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), $urandom);

    do_reset("reset2");
    for (int i = 0; i < 7; i++) step("mid_fill7", 1'b1, 1'b0, $urandom);
    do_reset("mid_reset");
    chk("mid_reset_cnt0", 64'(count), 64'd0);
    step("a5_write", 1'b1, 1'b0, 32'hA5);
    step("a5_read", 1'b0, 1'b1, '0);
    chk("a5_value", 64'(rdata), 64'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO buffer with a parameterised data width and a power-of-two depth.
- Full and empty status flags; registered read data.
- Used as the elastic buffer between the packet-parser ingress and downstream consumers.
- Write and read ports are independent, and each may fire in the same cycle.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge triggered.
- rst  input  1  synchronous, active-high reset.
- wdata  input  WIDTH  write data.
- wr_en  input  1  write request.
- full_flag  output  1  high when the FIFO holds DEPTH entries.
- rdata  output  WIDTH  read data, registered.
- rd_en  input  1  read request.
- empty_flag  output  1  high when the FIFO holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst high at a rising edge of clk):
  - Write and read pointers are cleared to 0 and count=0.
  - empty_flag=1, full_flag=0, rdata=0.
  - Storage array contents are not reset.
  - rst has priority over wr_en and rd_en in the same cycle.
- Pointers:
  - ADDR_W = $clog2(DEPTH). Each pointer is ADDR_W+1 bits; the extra MSB is a wrap bit.
  - empty_flag = (wptr == rptr).
  - full_flag = (addresses equal) and (wrap bits differ).
  - Both flags are combinational from the registered pointers, so they are valid in the cycle after the pointer update.
- Write: accepted at a rising edge when wr_en=1 and full_flag=0.
  - mem[wptr[ADDR_W-1:0]] <= wdata, then wptr increments.
  - A write while full is dropped silently; pointers and memory are unchanged.
- Read: accepted at a rising edge when rd_en=1 and empty_flag=0.
  - rdata <= mem[rptr[ADDR_W-1:0]], then rptr increments.
  - Read latency is 1 cycle: data is valid on rdata in the cycle after the accepting edge.
  - A read while empty is ignored and rdata holds its value.
  - rdata also holds its value whenever no read is accepted.
- Simultaneous wr_en and rd_en:
  - Each request is qualified independently against the flags as they stand before the edge.
  - Empty: the write is accepted, the read is rejected, count goes 0->1.
  - Full: the read is accepted, the write is rejected, count goes DEPTH->DEPTH-1.
  - Otherwise both are accepted and count is unchanged.
- Wrap-around: pointers roll over modulo 2*DEPTH. Data order is preserved across wraps; there is no bubble.
- count: registered, equal to wptr - rptr, updated in the same cycle as the pointers.
- Ordering is strict first-in first-out.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added: overflow (1 bit) and underflow (1 bit).
  - overflow is set to 1 at an edge where wr_en=1 and the write is rejected because the FIFO is full.
  - underflow is set to 1 at an edge where rd_en=1 and empty_flag=1.
  - Both are sticky until rst and reset to 0.
- When undefined, the ports do not exist and there are no error registers. All other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default WIDTH and DEPTH constants;
  - a function ptr_width(depth) returning $clog2(depth)+1.
- Sub-module fifo_mem: a simple dual-port register array with a write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
- The top-level fifo owns pointers, flags, count and the optional error logic.

Test Plan:
- Reset: hold rst=1 for 1 cycle -> empty_flag=1, full_flag=0, count=0, rdata=0.
- Fill: write 0..15 on consecutive cycles -> count=16, full_flag=1 after the 16th edge, empty_flag=0 from the cycle after the first write.
- Overflow: while full, write 99 -> ignored, count stays 16, and overflow=1 when the macro is defined. A later drain returns 0..15 with no 99.
- Drain: 16 consecutive reads -> rdata shows 0,1,...,15, each one cycle after its read edge. empty_flag=1 after the last read, and a further read leaves rdata=15 (and sets underflow when enabled).
- Wrap and simultaneous: write 10 words, read 10, then write 12 words (pointers wrap) -> reads return the 12 words in order.
  - With 5 entries, concurrent wr/rd for 20 cycles -> count stays 5.
  - Concurrent wr/rd while empty -> count 1; while full -> count 15.
- Mid-operation reset: with 7 entries, assert rst -> empty_flag=1 and count=0 next cycle. A subsequent write of 0xA5 followed by a read returns 0xA5.
